// File: rtl/add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : add_sequencer
// Description : Multi-word vector adder R = A + B over a single-port RAM,
//               three cycles per 32-bit word. ADDSEQ_SUB_EN enables A - B.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] base_a,
    input  logic [10:0] base_b,
    input  logic [10:0] base_r,
    input  logic [10:0] len,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic        carry_out,
    output logic [10:0] addr_arith,
    output logic        we_arith,
    output logic [31:0] data_arith,
    input  logic [31:0] q_arith
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_base_a;
    logic [10:0] r_base_b;
    logic [10:0] r_base_r;
    logic [10:0] r_len;
    logic [10:0] r_idx;
    logic [31:0] r_op_a;
    logic        r_carry;
    logic        r_carry_out;
    logic        r_sub;
    logic        w_sub_in;
    logic [31:0] w_op_b;
    logic [32:0] w_sum;
    logic        w_last;

`ifdef ADDSEQ_SUB_EN
    assign w_sub_in = sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_sub_in     = 1'b0;
`endif

    // Subtraction is A + ~B + 1: the +1 comes from the carry register seed.
    assign w_op_b = r_sub ? ~q_arith : q_arith;
    assign w_sum  = {1'b0, r_op_a} + {1'b0, w_op_b} + {32'd0, r_carry};
    assign w_last = (r_idx == (r_len - 11'd1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base_a    <= 11'd0;
            r_base_b    <= 11'd0;
            r_base_r    <= 11'd0;
            r_len       <= 11'd0;
            r_idx       <= 11'd0;
            r_op_a      <= 32'd0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_sub       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_a    <= base_a;
                        r_base_b    <= base_b;
                        r_base_r    <= base_r;
                        r_len       <= len;
                        r_sub       <= w_sub_in;
                        r_idx       <= 11'd0;
                        r_carry     <= w_sub_in;
                        r_carry_out <= 1'b0;
                    end
                end
                S_RD_B: begin
                    r_op_a <= q_arith;
                end
                S_WR: begin
                    r_carry <= w_sum[32];
                    r_idx   <= r_idx + 11'd1;
                    // Loaded on entry to DONE so it is valid alongside the done pulse.
                    if (w_last) begin
                        r_carry_out <= w_sum[32];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        addr_arith  = 11'd0;
        we_arith    = 1'b0;
        data_arith  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == 11'd0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                busy        = 1'b1;
                addr_arith  = r_base_a + r_idx;
                w_state_nxt = S_RD_B;
            end
            S_RD_B: begin
                busy        = 1'b1;
                addr_arith  = r_base_b + r_idx;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                busy        = 1'b1;
                addr_arith  = r_base_r + r_idx;
                we_arith    = 1'b1;
                data_arith  = w_sum[31:0];
                w_state_nxt = w_last ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign carry_out = r_carry_out;

endmodule
`default_nettype wire
